hicore_bjp_sched: RTL and testbench

Branch/jump reservation station and issue scheduler in front of the BJP execution unit. It accepts dispatched branch/jump micro-ops and holds them until both source operands are ready. Each cycle it selects the oldest ready entry and drives the issue-to-BJP handshake. A pipeline flush drains it. It sits between dispatch/rename and the BJP unit; the BJP unit writes back to the ROB.

---
 rtl/hicore_bjp_sched_pkg.sv | 7 +
 rtl/hicore_bjp_sched_entry.sv | 60 ++++++
 rtl/hicore_bjp_sched.sv | 112 +++++++++++
 tb/tb_hicore_bjp_sched.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/hicore_bjp_sched_pkg.sv
// hicore_bjp_sched_pkg: default geometry shared by the BJP reservation station and its slots.
package hicore_bjp_sched_pkg;
  localparam int HICORE_BJP_RS_DEPTH = 4;
  localparam int HICORE_PREG_TAG_SIZE = 6;
  localparam int HICORE_ISSUE2ALU_SIZE = 16;
  localparam int HICORE_REG_SIZE = 32;
endpackage

// File: rtl/hicore_bjp_sched_entry.sv
// hicore_bjp_rs_entry: one reservation-station slot with wakeup snoop and ready flag.
module hicore_bjp_rs_entry
  import hicore_bjp_sched_pkg::*;
#(
  parameter int TAG_W = HICORE_PREG_TAG_SIZE,
  parameter int INFO_W = HICORE_ISSUE2ALU_SIZE,
  parameter int REG_W = HICORE_REG_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              ld_valid,
  input  logic              ld_rs1_rdy,
  input  logic              ld_rs2_rdy,
  input  logic [TAG_W-1:0]  ld_rs1_tag,
  input  logic [TAG_W-1:0]  ld_rs2_tag,
  input  logic [INFO_W-1:0] ld_info,
  input  logic [REG_W-1:0]  ld_rd,
  input  logic              wk0_valid,
  input  logic [TAG_W-1:0]  wk0_tag,
  input  logic              wk1_valid,
  input  logic [TAG_W-1:0]  wk1_tag,
  output logic              valid,
  output logic [TAG_W-1:0]  rs1_tag,
  output logic [TAG_W-1:0]  rs2_tag,
  output logic [INFO_W-1:0] info,
  output logic [REG_W-1:0]  rd,
  output logic              woke_rs1,
  output logic              woke_rs2,
  output logic              eligible
);
  logic rs1_rdy, rs2_rdy;
  // woke_* include this cycle's broadcasts so the value survives a move to another slot
  assign woke_rs1 = rs1_rdy | (wk0_valid & (wk0_tag == rs1_tag)) | (wk1_valid & (wk1_tag == rs1_tag));
  assign woke_rs2 = rs2_rdy | (wk0_valid & (wk0_tag == rs2_tag)) | (wk1_valid & (wk1_tag == rs2_tag));
  assign eligible = valid & rs1_rdy & rs2_rdy;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      rs1_rdy <= 1'b0;
      rs2_rdy <= 1'b0;
      rs1_tag <= '0;
      rs2_tag <= '0;
      info <= '0;
      rd <= '0;
    end else if (clr) begin
      valid <= 1'b0;
      rs1_rdy <= 1'b0;
      rs2_rdy <= 1'b0;
    end else begin
      valid <= ld_valid;
      rs1_rdy <= ld_rs1_rdy;
      rs2_rdy <= ld_rs2_rdy;
      rs1_tag <= ld_rs1_tag;
      rs2_tag <= ld_rs2_tag;
      info <= ld_info;
      rd <= ld_rd;
    end
  end
endmodule

// File: rtl/hicore_bjp_sched.sv
// hicore_bjp_sched: collapsing-queue reservation station issuing the oldest ready branch/jump to BJP.
module hicore_bjp_sched
  import hicore_bjp_sched_pkg::*;
#(
  parameter int DEPTH = HICORE_BJP_RS_DEPTH,
  parameter int TAG_W = HICORE_PREG_TAG_SIZE,
  parameter int INFO_W = HICORE_ISSUE2ALU_SIZE,
  parameter int REG_W = HICORE_REG_SIZE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_disp_valid,
  output logic                       o_disp_ready,
  input  logic [INFO_W-1:0]          i_disp_info,
  input  logic [REG_W-1:0]           i_disp_rd_result,
  input  logic [TAG_W-1:0]           i_disp_rs1_tag,
  input  logic [TAG_W-1:0]           i_disp_rs2_tag,
  input  logic                       i_disp_rs1_rdy,
  input  logic                       i_disp_rs2_rdy,
  input  logic                       i_wk0_valid,
  input  logic                       i_wk1_valid,
  input  logic [TAG_W-1:0]           i_wk0_tag,
  input  logic [TAG_W-1:0]           i_wk1_tag,
  output logic                       o_issue2bjp_valid,
  input  logic                       i_issue2bjp_ready,
  output logic [INFO_W-1:0]          o_issue2bjp_info,
  output logic [REG_W-1:0]           o_issue2bjp_rd_result,
  output logic                       o_issue2bjp_cancel,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = $clog2(DEPTH);
  logic [CW-1:0] cnt, cnt_c;
  logic [SW-1:0] sel;
  logic [DEPTH-1:0] elig, q_valid, w_rs1, w_rs2;
  logic [TAG_W-1:0] q_t1 [DEPTH];
  logic [TAG_W-1:0] q_t2 [DEPTH];
  logic [INFO_W-1:0] q_info [DEPTH];
  logic [REG_W-1:0] q_rd [DEPTH];
  logic issue_fire, disp_fire, d_rs1, d_rs2;
  assign o_disp_ready = cnt != CW'(DEPTH);
  assign o_count = cnt;
  assign o_issue2bjp_valid = |elig;
  assign o_issue2bjp_cancel = o_issue2bjp_valid & flush;
  assign o_issue2bjp_info = o_issue2bjp_valid ? q_info[sel] : '0;
  assign o_issue2bjp_rd_result = o_issue2bjp_valid ? q_rd[sel] : '0;
  assign issue_fire = o_issue2bjp_valid & i_issue2bjp_ready & ~flush;
  assign disp_fire = i_disp_valid & o_disp_ready & ~flush;
  assign cnt_c = cnt - CW'(issue_fire);
  // the dispatching micro-op snoops the wakeup ports so a same-cycle broadcast is not lost
  assign d_rs1 = i_disp_rs1_rdy | (i_wk0_valid & (i_wk0_tag == i_disp_rs1_tag)) | (i_wk1_valid & (i_wk1_tag == i_disp_rs1_tag));
  assign d_rs2 = i_disp_rs2_rdy | (i_wk0_valid & (i_wk0_tag == i_disp_rs2_tag)) | (i_wk1_valid & (i_wk1_tag == i_disp_rs2_tag));
  always_comb begin
    sel = '0;
    for (int k = DEPTH - 1; k >= 0; k--) if (elig[k]) sel = SW'(k);
  end
  always_ff @(posedge clk) begin
    if (rst || flush) cnt <= '0;
    else cnt <= cnt_c + CW'(disp_fire);
  end
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic sh, app, n_valid, n_rs1, n_rs2;
    logic [TAG_W-1:0] n_t1, n_t2;
    logic [INFO_W-1:0] n_info;
    logic [REG_W-1:0] n_rd;
    // slots at or above the issued one pull their upper neighbour; the top slot pulls an empty one
    if (i < DEPTH - 1) begin : g_up
      assign n_valid = q_valid[i+1];
      assign n_rs1 = w_rs1[i+1];
      assign n_rs2 = w_rs2[i+1];
      assign n_t1 = q_t1[i+1];
      assign n_t2 = q_t2[i+1];
      assign n_info = q_info[i+1];
      assign n_rd = q_rd[i+1];
    end else begin : g_top
      assign n_valid = 1'b0;
      assign n_rs1 = 1'b0;
      assign n_rs2 = 1'b0;
      assign n_t1 = '0;
      assign n_t2 = '0;
      assign n_info = '0;
      assign n_rd = '0;
    end
    assign sh = issue_fire & (SW'(i) >= sel);
    assign app = disp_fire & (cnt_c == CW'(i));
    hicore_bjp_rs_entry #(.TAG_W(TAG_W), .INFO_W(INFO_W), .REG_W(REG_W)) u_entry (
      .clk(clk),
      .rst(rst),
      .clr(flush),
      .ld_valid(app | (sh ? n_valid : q_valid[i])),
      .ld_rs1_rdy(app ? d_rs1 : sh ? n_rs1 : w_rs1[i]),
      .ld_rs2_rdy(app ? d_rs2 : sh ? n_rs2 : w_rs2[i]),
      .ld_rs1_tag(app ? i_disp_rs1_tag : sh ? n_t1 : q_t1[i]),
      .ld_rs2_tag(app ? i_disp_rs2_tag : sh ? n_t2 : q_t2[i]),
      .ld_info(app ? i_disp_info : sh ? n_info : q_info[i]),
      .ld_rd(app ? i_disp_rd_result : sh ? n_rd : q_rd[i]),
      .wk0_valid(i_wk0_valid),
      .wk0_tag(i_wk0_tag),
      .wk1_valid(i_wk1_valid),
      .wk1_tag(i_wk1_tag),
      .valid(q_valid[i]),
      .rs1_tag(q_t1[i]),
      .rs2_tag(q_t2[i]),
      .info(q_info[i]),
      .rd(q_rd[i]),
      .woke_rs1(w_rs1[i]),
      .woke_rs2(w_rs2[i]),
      .eligible(elig[i])
    );
  end
endmodule

// File: tb/tb_hicore_bjp_sched.sv
// tb_hicore_bjp_sched: directed vector table, reset/flush sequences and random run against a queue model.
module tb_hicore_bjp_sched;
  import hicore_bjp_sched_pkg::*;
  localparam int DEPTH = HICORE_BJP_RS_DEPTH;
  localparam int TAG_W = HICORE_PREG_TAG_SIZE;
  localparam int INFO_W = HICORE_ISSUE2ALU_SIZE;
  localparam int REG_W = HICORE_REG_SIZE;
  localparam int CW = $clog2(DEPTH+1);
  logic clk = 1'b0;
  logic rst, disp_valid, disp_ready, rs1_rdy, rs2_rdy, wk0_valid, wk1_valid;
  logic iss_valid, iss_ready, iss_cancel, flush;
  logic [INFO_W-1:0] disp_info, iss_info;
  logic [REG_W-1:0] disp_rd, iss_rd;
  logic [TAG_W-1:0] rs1_tag, rs2_tag, wk0_tag, wk1_tag;
  logic [CW-1:0] count;
  always #5 clk = ~clk;
  hicore_bjp_sched dut (
    .clk(clk), .rst(rst),
    .i_disp_valid(disp_valid), .o_disp_ready(disp_ready),
    .i_disp_info(disp_info), .i_disp_rd_result(disp_rd),
    .i_disp_rs1_tag(rs1_tag), .i_disp_rs2_tag(rs2_tag),
    .i_disp_rs1_rdy(rs1_rdy), .i_disp_rs2_rdy(rs2_rdy),
    .i_wk0_valid(wk0_valid), .i_wk1_valid(wk1_valid),
    .i_wk0_tag(wk0_tag), .i_wk1_tag(wk1_tag),
    .o_issue2bjp_valid(iss_valid), .i_issue2bjp_ready(iss_ready),
    .o_issue2bjp_info(iss_info), .o_issue2bjp_rd_result(iss_rd),
    .o_issue2bjp_cancel(iss_cancel), .flush(flush), .o_count(count)
  );
  typedef struct {
    logic [TAG_W-1:0] t1, t2;
    bit r1, r2;
    logic [INFO_W-1:0] info;
    logic [REG_W-1:0] rd;
  } ent_t;
  typedef struct {
    bit dv; int info; bit r1, r2; int t1, t2;
    bit w0v; int w0t; bit w1v; int w1t; bit ir, fl;
    bit ev; int einfo; int ec; bit edr, ecn;
  } row_t;
  ent_t q[$];
  int total = 0, bad = 0, msel;
  row_t rows[29];
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  function automatic bit hit(logic [TAG_W-1:0] t);
    return (wk0_valid && wk0_tag == t) || (wk1_valid && wk1_tag == t);
  endfunction
  // oldest entry with both operands ready, as seen before this cycle's wakeups
  task automatic check_model();
    bit ev;
    msel = -1;
    for (int i = 0; i < q.size(); i++) if (q[i].r1 && q[i].r2) begin msel = i; break; end
    ev = msel >= 0;
    chk("valid", 64'(iss_valid), 64'(ev));
    chk("info", 64'(iss_info), ev ? 64'(q[msel].info) : 64'd0);
    chk("rd", 64'(iss_rd), ev ? 64'(q[msel].rd) : 64'd0);
    chk("disp_ready", 64'(disp_ready), 64'(q.size() < DEPTH));
    chk("count", 64'(count), 64'(q.size()));
    chk("cancel", 64'(iss_cancel), 64'(ev && flush));
  endtask
  task automatic model_update();
    bit dfire, ifire;
    if (rst || flush) q.delete();
    else begin
      dfire = disp_valid && q.size() < DEPTH;
      ifire = msel >= 0 && iss_ready;
      if (ifire) q.delete(msel);
      foreach (q[i]) begin
        if (hit(q[i].t1)) q[i].r1 = 1;
        if (hit(q[i].t2)) q[i].r2 = 1;
      end
      if (dfire) q.push_back('{rs1_tag, rs2_tag, rs1_rdy | hit(rs1_tag), rs2_rdy | hit(rs2_tag), disp_info, disp_rd});
    end
  endtask
  task automatic tick();
    #1;
    check_model();
    @(posedge clk);
    model_update();
    #1;
  endtask
  task automatic idle();
    disp_valid = 0; rs1_rdy = 0; rs2_rdy = 0; rs1_tag = '0; rs2_tag = '0;
    disp_info = '0; disp_rd = '0; wk0_valid = 0; wk1_valid = 0; wk0_tag = '0; wk1_tag = '0;
    iss_ready = 1; flush = 0;
  endtask
  function automatic row_t mk(bit dv, int info, bit r1, bit r2, int t1, int t2, bit w0v, int w0t,
                              bit w1v, int w1t, bit ir, bit fl, bit ev, int einfo, int ec, bit edr, bit ecn);
    return '{dv, info, r1, r2, t1, t2, w0v, w0t, w1v, w1t, ir, fl, ev, einfo, ec, edr, ecn};
  endfunction
  initial begin
    rows[0]  = mk(1, 'h15, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    rows[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 'h15, 1, 1, 0);
    rows[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    rows[3]  = mk(1, 'hA1, 0, 1, 5, 7, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    rows[4]  = mk(1, 'hB2, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0);
    rows[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 'hB2, 2, 1, 0);
    rows[6]  = mk(0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 1, 0, 0, 0, 1, 1, 0);
    rows[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 'hA1, 1, 1, 0);
    rows[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    rows[9]  = mk(1, 'hC3, 1, 0, 0, 9, 0, 0, 1, 9, 1, 0, 0, 0, 0, 1, 0);
    rows[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 'hC3, 1, 1, 0);
    rows[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    rows[12] = mk(1, 'hD0, 0, 1, 20, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    rows[13] = mk(1, 'hD1, 0, 1, 21, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0);
    rows[14] = mk(1, 'hD2, 0, 1, 22, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 1, 0);
    rows[15] = mk(1, 'hD3, 0, 1, 23, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3, 1, 0);
    rows[16] = mk(1, 'hE4, 1, 1, 0, 0, 1, 21, 0, 0, 1, 0, 0, 0, 4, 0, 0);
    rows[17] = mk(1, 'hE4, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 'hD1, 4, 0, 0);
    rows[18] = mk(1, 'hE4, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3, 1, 0);
    rows[19] = mk(0, 0, 0, 0, 0, 0, 1, 22, 0, 0, 1, 0, 1, 'hE4, 4, 0, 0);
    rows[20] = mk(0, 0, 0, 0, 0, 0, 1, 20, 0, 0, 1, 0, 1, 'hD2, 3, 1, 0);
    rows[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 23, 1, 0, 1, 'hD0, 2, 1, 0);
    rows[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 'hD3, 1, 1, 0);
    rows[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    rows[24] = mk(1, 'hF0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    rows[25] = mk(1, 'hF1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'hF0, 1, 1, 0);
    rows[26] = mk(1, 'hF2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'hF0, 2, 1, 0);
    rows[27] = mk(1, 'hF3, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 'hF0, 3, 1, 1);
    rows[28] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    idle();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    q.delete();
    #1;
    chk("reset_ready", 64'(disp_ready), 64'd1);
    chk("reset_valid", 64'(iss_valid), 64'd0);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_info", 64'(iss_info), 64'd0);
    for (int r = 0; r < 29; r++) begin
      disp_valid = rows[r].dv; disp_info = INFO_W'(rows[r].info);
      disp_rd = {16'hA5A5, 16'(rows[r].info)};
      rs1_rdy = rows[r].r1; rs2_rdy = rows[r].r2;
      rs1_tag = TAG_W'(rows[r].t1); rs2_tag = TAG_W'(rows[r].t2);
      wk0_valid = rows[r].w0v; wk0_tag = TAG_W'(rows[r].w0t);
      wk1_valid = rows[r].w1v; wk1_tag = TAG_W'(rows[r].w1t);
      iss_ready = rows[r].ir; flush = rows[r].fl;
      #1;
      chk($sformatf("row%0d_valid", r), 64'(iss_valid), 64'(rows[r].ev));
      chk($sformatf("row%0d_info", r), 64'(iss_info), 64'(INFO_W'(rows[r].einfo)));
      chk($sformatf("row%0d_count", r), 64'(count), 64'(rows[r].ec));
      chk($sformatf("row%0d_ready", r), 64'(disp_ready), 64'(rows[r].edr));
      chk($sformatf("row%0d_cancel", r), 64'(iss_cancel), 64'(rows[r].ecn));
      tick();
    end
    // reset in the middle of operation with two live entries
    idle();
    iss_ready = 0; disp_valid = 1; rs1_rdy = 1; rs2_rdy = 1; disp_info = 'h51; disp_rd = 'h1234;
    tick();
    disp_info = 'h52;
    tick();
    idle();
    iss_ready = 0;
    #1;
    chk("pre_rst_count", 64'(count), 64'd2);
    rst = 1;
    tick();
    rst = 0;
    idle();
    #1;
    chk("rst_ready", 64'(disp_ready), 64'd1);
    chk("rst_valid", 64'(iss_valid), 64'd0);
    chk("rst_cancel", 64'(iss_cancel), 64'd0);
    chk("rst_info", 64'(iss_info), 64'd0);
    chk("rst_rd", 64'(iss_rd), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    for (int c = 0; c < 800; c++) begin
      disp_valid = $urandom_range(0, 3) != 0;
      disp_info = INFO_W'($urandom);
      disp_rd = $urandom;
      rs1_tag = TAG_W'($urandom_range(0, 7));
      rs2_tag = TAG_W'($urandom_range(0, 7));
      rs1_rdy = $urandom_range(0, 2) == 0;
      rs2_rdy = $urandom_range(0, 2) == 0;
      wk0_valid = $urandom_range(0, 2) == 0;
      wk1_valid = $urandom_range(0, 3) == 0;
      wk0_tag = TAG_W'($urandom_range(0, 7));
      wk1_tag = TAG_W'($urandom_range(0, 7));
      iss_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 39) == 0;
      rst = $urandom_range(0, 99) == 0;
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
